// File: rtl/sensor_responder_if.sv
// sensor_responder_if: request/response bundle between the cycle-trainer
// controller + ADC/pulse front end (master) and sensor_responder (slave).
interface sensor_responder_if;
   logic        sensor_request;
   logic [11:0] adc_inp;
   logic        pulse_bn;
   logic [7:0]  temp;
   logic [7:0]  pulse;
   logic        sensor_recieved;
   logic        busy;
   logic        timeout_err;

   modport master (
      output sensor_request, adc_inp, pulse_bn,
      input  temp, pulse, sensor_recieved, busy, timeout_err
   );

   modport slave (
      input  sensor_request, adc_inp, pulse_bn,
      output temp, pulse, sensor_recieved, busy, timeout_err
   );
endinterface

// File: rtl/sensor_responder.sv
// sensor_responder: on a level request, averages 2^AVG_LOG2 ADC samples taken
// every SAMPLE_DIV clocks, counts pulse_bn rising edges over the same window,
// then presents temp/pulse with sensor_recieved held until request drops.
// Optional macro SENSOR_RESP_TIMEOUT_EN: bounds the HOLD phase to TIMEOUT
// cycles and raises a sticky timeout_err when the controller never releases.
module sensor_responder #(
   parameter int SAMPLE_DIV = 8,
   parameter int AVG_LOG2   = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic               clock,
   input  logic               rst,
   sensor_responder_if.slave  bus
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int NSAMP = 1 << AVG_LOG2;

   // elaboration-time parameter legality
   if (SAMPLE_DIV < 2) begin : g_bad_div
      $error("sensor_responder: SAMPLE_DIV must be >= 2");
   end
   if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
      $error("sensor_responder: AVG_LOG2 must be 0..4");
   end
   if (TIMEOUT < 1) begin : g_bad_tmo
      $error("sensor_responder: TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_CONVERT, S_HOLD} state_t;

   state_t             r_state, w_next;
   logic [DIV_W-1:0]   r_div;
   logic [4:0]         r_nsamp;
   logic [15:0]        r_acc;
   logic [7:0]         r_cnt;
   logic               r_pulse_q;
   logic [7:0]         r_temp, r_pulse;
   logic               r_busy, r_rcv;

   logic               w_start, w_capture, w_last, w_update, w_edge;
   logic               w_arm, w_tmo_hit;

   assign w_edge    = bus.pulse_bn & ~r_pulse_q;
   assign w_capture = (r_state == S_SAMPLE) && (r_div == DIV_W'(SAMPLE_DIV - 1));
   assign w_last    = w_capture && (r_nsamp == 5'(NSAMP - 1));

`ifdef SENSOR_RESP_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0]   r_tmo;
   logic               r_err, r_need_low;

   // after a timeout the request must be seen low before a new window may start
   assign w_arm = ~r_need_low;

   // HOLD dwell counter, sticky error and re-arm guard
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_tmo      <= '0;
         r_err      <= 1'b0;
         r_need_low <= 1'b0;
      end else begin
         r_tmo <= (r_state == S_HOLD && w_next == S_HOLD) ? r_tmo + TMO_W'(1) : '0;
         if (w_tmo_hit) begin
            r_err      <= 1'b1;
            r_need_low <= 1'b1;
         end else if (!bus.sensor_request) begin
            r_need_low <= 1'b0;
         end
      end
   end

   assign bus.timeout_err = r_err;
`else
   assign w_arm           = 1'b1;
   assign bus.timeout_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clock) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // next state; a dropped request aborts ahead of any other progress
   always_comb begin
      w_next    = r_state;
      w_start   = 1'b0;
      w_update  = 1'b0;
      w_tmo_hit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.sensor_request && w_arm) begin
               w_next  = S_SAMPLE;
               w_start = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (!bus.sensor_request) w_next = S_IDLE;
            else if (w_last)         w_next = S_CONVERT;
         end
         S_CONVERT: begin
            if (!bus.sensor_request) begin
               w_next = S_IDLE;
            end else begin
               w_next   = S_HOLD;
               w_update = 1'b1;
            end
         end
         S_HOLD: begin
            if (!bus.sensor_request) begin
               w_next = S_IDLE;
            end
`ifdef SENSOR_RESP_TIMEOUT_EN
            else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
               w_next    = S_IDLE;
               w_tmo_hit = 1'b1;
            end
`endif
         end
         default: w_next = S_IDLE;
      endcase
   end

   // sampling window, accumulation, edge counting and result registers
   always_ff @(posedge clock) begin
      if (!rst) begin
         r_div     <= '0;
         r_nsamp   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_pulse_q <= 1'b0;
         r_temp    <= '0;
         r_pulse   <= '0;
         r_busy    <= 1'b0;
         r_rcv     <= 1'b0;
      end else begin
         r_pulse_q <= bus.pulse_bn;
         if (w_start) begin
            r_div   <= '0;
            r_nsamp <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
         end else if (r_state == S_SAMPLE) begin
            r_div <= (r_div == DIV_W'(SAMPLE_DIV - 1)) ? '0 : r_div + DIV_W'(1);
            if (w_capture) begin
               r_acc   <= r_acc + {4'd0, bus.adc_inp};
               r_nsamp <= r_nsamp + 5'd1;
            end
            if (w_edge && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
         end
         // average then keep bits [11:4]; acc >> (AVG_LOG2+4) never exceeds 8 bits
         if (w_update) begin
            r_temp  <= 8'(r_acc >> (AVG_LOG2 + 4));
            r_pulse <= r_cnt;
         end
         r_busy <= (w_next == S_SAMPLE) || (w_next == S_CONVERT);
         r_rcv  <= (w_next == S_HOLD);
      end
   end

   assign bus.temp            = r_temp;
   assign bus.pulse           = r_pulse;
   assign bus.busy            = r_busy;
   assign bus.sensor_recieved = r_rcv;

endmodule

// File: doc/sensor_responder.md
# sensor_responder

Responder end of the trainer's sensor request/received handshake. When the controller raises `sensor_request`, this block averages a burst of ADC samples, counts kicker pulse edges over the same window, and returns an 8-bit temperature and pulse count with `sensor_recieved` held under a four-phase handshake. It sits between the ADC/pulse front end and the cycle-trainer controller.

## Interface
- `SAMPLE_DIV`, default 8: clocks per ADC sample interval, ≥2.
- `AVG_LOG2`, default 2: log2 of samples averaged, range 0–4.
- `TIMEOUT`, default 1024: hold-cycle limit, used only with the config macro.
- `clock`  input  1  sole clock; all logic on its rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `sensor_request`  input  1  level request from the controller.
- `adc_inp`  input  12  unsigned ADC code, synchronous to `clock`.
- `pulse_bn`  input  1  kicker pulse, synchronous; rising edges are counted.
- `temp`  output  8  averaged temperature code.
- `pulse`  output  8  pulse-edge count for the last completed window.
- `sensor_recieved`  output  1  response valid / acknowledge.
- `busy`  output  1  high in SAMPLE and CONVERT.
- `timeout_err`  output  1  sticky handshake-timeout flag.

## Operation
- FSM states:
  - IDLE → SAMPLE when `sensor_request`=1.
  - SAMPLE → CONVERT after 2^AVG_LOG2 captures.
  - CONVERT → HOLD unconditionally.
  - HOLD → IDLE when `sensor_request`=0.
- SAMPLE: divider counts 0..SAMPLE_DIV-1 and is cleared on SAMPLE entry.
  - `adc_inp` is added to the accumulator when divider = SAMPLE_DIV-1.
  - Accumulator is 16 bits, cleared on SAMPLE entry, cannot overflow.
- Pulse counting: `pulse_bn` is edge-detected against a registered copy (reset 0).
  - Each rising edge seen in a SAMPLE cycle increments an 8-bit window counter.
  - The counter saturates at 255 and is cleared on SAMPLE entry.
- CONVERT: avg = acc >> AVG_LOG2; `temp` ← avg[11:4] (truncation); `pulse` ← window count.
  - `temp` and `pulse` change only at the end of CONVERT.
- HOLD: `sensor_recieved`=1, and `temp`/`pulse` stay stable.
- Abort: `sensor_request`=0 in SAMPLE or CONVERT returns to IDLE next cycle.
  - No response is issued; `temp`/`pulse` keep their previous values.
  - An abort in the CONVERT cycle takes priority over the output update.
- Request high again on the IDLE cycle after HOLD starts a fresh window; there is no back-to-back reuse.
- Reset values: state IDLE, `temp`=0, `pulse`=0, `sensor_recieved`=0, `busy`=0, `timeout_err`=0, counters/accumulator 0.
- Reset mid-operation drops to IDLE the next cycle and overrides all other conditions.

## Timing
- Cycle 0 is the first IDLE cycle with request high.
- SAMPLE spans cycles 1..N, where N = SAMPLE_DIV·2^AVG_LOG2 (32 with defaults).
- CONVERT is cycle N+1.
- `sensor_recieved` rises at cycle N+2 (34 with defaults); `temp`/`pulse` are valid the same cycle.
- Request falls at cycle k in HOLD → `sensor_recieved`=0 at k+1, state IDLE at k+1.
- `busy` is registered from the state: high cycles 1..N+1.
- Pulse edges count when the registered edge is detected in cycles 1..N; an edge on cycle N+1 is excluded.

## Configuration
- `SENSOR_RESP_TIMEOUT_EN` defined:
  - A counter runs in HOLD; reaching TIMEOUT cycles with request still high forces IDLE, drops `sensor_recieved`, and sets `timeout_err`.
  - `timeout_err` clears only on reset.
  - Re-entry to SAMPLE requires request low for at least one cycle after the timeout.
- Not defined: HOLD waits indefinitely; `timeout_err` is tied 0.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → all outputs 0; `busy`=0 one cycle after release.
- Constant `adc_inp`=0x800, request high from cycle 0, defaults → `sensor_recieved`=1 at cycle 34, `temp`=0x80, `pulse`=0; request low at 40 → `sensor_recieved`=0 at 41.
- Averaging: samples 0x100, 0x200, 0x300, 0x400 → acc 0xA00, avg 0x280, `temp`=0x28.
- Pulses: 5 rising edges on `pulse_bn` within cycles 1..32 → `pulse`=5; with SAMPLE_DIV=200 and 300 edges → `pulse`=255.
- Abort: prior response `temp`=0x80; request drops at cycle 10 → IDLE at 11, `sensor_recieved` never asserted, `temp`=0x80 retained.
- Timeout with `SENSOR_RESP_TIMEOUT_EN` and TIMEOUT=16: request held high → `sensor_recieved` drops after 16 HOLD cycles, `timeout_err`=1 until reset; without the macro, `sensor_recieved` stays high.
